// File: rtl/amiga_clk_gen_if.sv
// Output bundle of the Amiga clock generator plus the PLL lock input.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a level or a single-cycle enable.
interface amiga_clk_gen_if;
    logic pll_locked;
    logic run;
    logic clk7_en;
    logic clk7n_en;
    logic c1;
    logic c3;
    logic cck;
    logic eclk;
    logic e_sync;

    // The generator side drives the timing outputs and receives the lock input.
    modport master (
        input  pll_locked,
        output run, clk7_en, clk7n_en, c1, c3, cck, eclk, e_sync
    );

    // The consumer side (chipset, CPU, and the PLL lock source).
    modport slave (
        output pll_locked,
        input  run, clk7_en, clk7n_en, c1, c3, cck, eclk, e_sync
    );
endinterface

// File: rtl/amiga_clk_gen.sv
// Qualifies PLL lock into the core run signal, then derives the Amiga enables and phases from one phase counter.
// Latency: run rises LOCK_CYCLES+3 clk after pll_locked rises; each enable/phase output lags its ph decode by 1 clk.
// Backpressure: none; free-running timing generator, and all outputs are forced low whenever lock is lost.
module amiga_clk_gen #(
    parameter int LOCK_CYCLES = 1024,
    parameter int LOCK_W      = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    amiga_clk_gen_if.master bus
);
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    state_t            state;
    logic              lk_meta;
    logic              lk_s;
    logic [LOCK_W-1:0] lock_cnt;
    logic [4:0]        ph;
    logic [3:0]        ecnt;
    logic              run_q;
    logic              clk7_q;
    logic              clk7n_q;
    logic              c1_q;
    logic              c3_q;
    logic              eclk_q;
    logic              esync_q;
    logic              run_ok;

    // Leaving RUN or losing lock kills the timing outputs on the same edge.
    assign run_ok = (state == RUN) && lk_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= bus.pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // Lock qualification FSM; run is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            run_q    <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    lock_cnt <= '0;
                    run_q    <= 1'b0;
                    if (lk_s) state <= STABLE;
                end
                STABLE: begin
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                        run_q    <= 1'b0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                        run_q    <= 1'b0;
                    end
                end
                RUN: begin
                    run_q <= lk_s;
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= WAIT_LOCK;
                    lock_cnt <= '0;
                    run_q    <= 1'b0;
                end
            endcase
        end
    end

    // Phase counter, E counter and registered decodes; all cleared outside RUN so a relock restarts cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n || !run_ok) begin
            ph      <= '0;
            ecnt    <= '0;
            clk7_q  <= 1'b0;
            clk7n_q <= 1'b0;
            c1_q    <= 1'b0;
            c3_q    <= 1'b0;
            eclk_q  <= 1'b0;
            esync_q <= 1'b0;
        end else begin
            ph      <= ph + 5'd1;
            clk7_q  <= (ph[3:0] == 4'd15);
            clk7n_q <= (ph[3:0] == 4'd7);
            c1_q    <= (ph >= 5'd8) && (ph <= 5'd23);
            c3_q    <= (ph >= 5'd16);
            eclk_q  <= (ecnt >= 4'd6);
            esync_q <= (ph[3:0] == 4'd15) && (ecnt == 4'd9);
            if (ph[3:0] == 4'd15) begin
                ecnt <= (ecnt == 4'd9) ? 4'd0 : ecnt + 4'd1;
            end
        end
    end

    assign bus.run      = run_q;
    assign bus.clk7_en  = clk7_q;
    assign bus.clk7n_en = clk7n_q;
    assign bus.c1       = c1_q;
    assign bus.c3       = c3_q;
    assign bus.cck      = c1_q;
    assign bus.eclk     = eclk_q;
    assign bus.e_sync   = esync_q;
endmodule
